// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: per-stage stall/flush/bubble, PC redirect, and
// deferral of a branch redirect that lands while the I-cache is mid-fetch.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_stall_i,
  input  logic             ICACHE_stall_i,
  input  logic             DCACHE_stall_i,
  input  logic             ID_redirect_i,
  input  logic [XLEN-1:0]  ID_target_i,
  output logic             PC_stall_o,
  output logic             PC_redirect_o,
  output logic [XLEN-1:0]  PC_target_o,
  output logic             IF_ID_stall_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_stall_o,
  output logic             ID_EX_bubble_o,
  output logic             EX_ME_stall_o,
  output logic             ME_WB_stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [0:0]      state, state_nxt;
  logic [XLEN-1:0] pend_target, pend_target_nxt;
  logic [CNT_W-1:0] stall_cnt, redirect_cnt;

  logic            pc_stall, pc_redirect, if_id_stall, if_id_flush;
  logic            id_ex_stall, id_ex_bubble, ex_me_stall, me_wb_stall;
  logic [XLEN-1:0] pc_target;

  // Next-state and control decode; D-cache stall dominates everything.
  always_comb begin
    state_nxt       = state;
    pend_target_nxt = pend_target;
    pc_stall        = 1'b0;
    pc_redirect     = 1'b0;
    if_id_stall     = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_stall     = 1'b0;
    id_ex_bubble    = 1'b0;
    ex_me_stall     = 1'b0;
    me_wb_stall     = 1'b0;
    pc_target       = ID_target_i;
    case (state)
      ST_RUN: begin
        if (DCACHE_stall_i) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_stall = 1'b1;
          ex_me_stall = 1'b1;
          me_wb_stall = 1'b1;
        end else if (forward_stall_i) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (ICACHE_stall_i) begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
          if (ID_redirect_i) begin
            pend_target_nxt = ID_target_i;
            state_nxt       = ST_PEND;
          end
        end else if (ID_redirect_i) begin
          pc_redirect = 1'b1;
          if_id_flush = 1'b1;
        end
      end
      default: begin
        pc_target = pend_target;
        if (DCACHE_stall_i) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_stall = 1'b1;
          ex_me_stall = 1'b1;
          me_wb_stall = 1'b1;
        end else begin
          id_ex_bubble = forward_stall_i;
          if_id_flush  = 1'b1;
          if (ICACHE_stall_i) begin
            pc_stall = 1'b1;
          end else begin
            pc_redirect = 1'b1;
            state_nxt   = ST_RUN;
          end
        end
      end
    endcase
  end

  // Outputs are forced quiet for as long as reset is held.
  always_comb begin
    PC_stall_o     = pc_stall     & ~rst;
    PC_redirect_o  = pc_redirect  & ~rst;
    IF_ID_stall_o  = if_id_stall  & ~rst;
    IF_ID_flush_o  = if_id_flush  & ~rst;
    ID_EX_stall_o  = id_ex_stall  & ~rst;
    ID_EX_bubble_o = id_ex_bubble & ~rst;
    EX_ME_stall_o  = ex_me_stall  & ~rst;
    ME_WB_stall_o  = me_wb_stall  & ~rst;
    PC_target_o    = rst ? '0 : pc_target;
    stall_cnt_o    = stall_cnt;
    redirect_cnt_o = redirect_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      pend_target <= '0;
    end else begin
      state       <= state_nxt;
      pend_target <= pend_target_nxt;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (pc_redirect && (redirect_cnt != {CNT_W{1'b1}}))
        redirect_cnt <= redirect_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed control vectors and counters.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fwd, ic, dc, redir;
  logic [31:0] tgt;

  logic        pc_stall, pc_redir, ifid_stall, ifid_flush;
  logic        idex_stall, idex_bub, exme_stall, mewb_stall;
  logic [31:0] pc_tgt, stall_cnt, redir_cnt;

  logic        pc_stall4, pc_redir4, ifid_stall4, ifid_flush4;
  logic        idex_stall4, idex_bub4, exme_stall4, mewb_stall4;
  logic [31:0] pc_tgt4;
  logic [3:0]  stall_cnt4, redir_cnt4;

  int n_cmp = 0;
  int n_err = 0;

  // {PC_stall, PC_redirect, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_bubble, EX_ME_stall, ME_WB_stall}
  logic [7:0] ctrl;
  assign ctrl = {pc_stall, pc_redir, ifid_stall, ifid_flush,
                 idex_stall, idex_bub, exme_stall, mewb_stall};

  localparam logic [7:0] C_IDLE  = 8'b0000_0000;
  localparam logic [7:0] C_FWD   = 8'b1010_0100;
  localparam logic [7:0] C_REDIR = 8'b0101_0000;
  localparam logic [7:0] C_ICW   = 8'b1001_0000;
  localparam logic [7:0] C_ICWB  = 8'b1001_0100;
  localparam logic [7:0] C_DC    = 8'b1010_1011;

  hazard_ctrl #(.CNT_W(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .forward_stall_i(fwd), .ICACHE_stall_i(ic), .DCACHE_stall_i(dc),
    .ID_redirect_i(redir), .ID_target_i(tgt),
    .PC_stall_o(pc_stall), .PC_redirect_o(pc_redir), .PC_target_o(pc_tgt),
    .IF_ID_stall_o(ifid_stall), .IF_ID_flush_o(ifid_flush),
    .ID_EX_stall_o(idex_stall), .ID_EX_bubble_o(idex_bub),
    .EX_ME_stall_o(exme_stall), .ME_WB_stall_o(mewb_stall),
    .stall_cnt_o(stall_cnt), .redirect_cnt_o(redir_cnt)
  );

  hazard_ctrl #(.CNT_W(4), .XLEN(32)) dut4 (
    .clk(clk), .rst(rst),
    .forward_stall_i(fwd), .ICACHE_stall_i(ic), .DCACHE_stall_i(dc),
    .ID_redirect_i(redir), .ID_target_i(tgt),
    .PC_stall_o(pc_stall4), .PC_redirect_o(pc_redir4), .PC_target_o(pc_tgt4),
    .IF_ID_stall_o(ifid_stall4), .IF_ID_flush_o(ifid_flush4),
    .ID_EX_stall_o(idex_stall4), .ID_EX_bubble_o(idex_bub4),
    .EX_ME_stall_o(exme_stall4), .ME_WB_stall_o(mewb_stall4),
    .stall_cnt_o(stall_cnt4), .redirect_cnt_o(redir_cnt4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fwd = 1'b0; ic = 1'b0; dc = 1'b1; redir = 1'b1; tgt = 32'h55;
    #2;
    chk("rst_ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("rst_target", pc_tgt, 32'h0);
    chk("rst_stall_cnt", stall_cnt, 32'h0);
    dc = 1'b0; redir = 1'b0; tgt = 32'h0;
    #1 rst = 1'b0;

    // Idle
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ctrl", 32'(ctrl), 32'(C_IDLE));
    end
    chk("idle_stall_cnt", stall_cnt, 32'h0);
    chk("idle_redir_cnt", redir_cnt, 32'h0);

    // Forward stall masks a redirect, then redirect goes through
    fwd = 1'b1; redir = 1'b1; tgt = 32'h100;
    #1;
    chk("fwd_ctrl", 32'(ctrl), 32'(C_FWD));
    tick();
    fwd = 1'b0;
    #1;
    chk("redir_ctrl", 32'(ctrl), 32'(C_REDIR));
    chk("redir_target", pc_tgt, 32'h100);
    tick();
    redir = 1'b0;
    chk("redir_cnt_1", redir_cnt, 32'd1);
    chk("fwd_stall_cnt", stall_cnt, 32'd1);

    // Redirect during I-cache wait is held until the fetch completes
    pulse_reset();
    chk("reset_redir_cnt", redir_cnt, 32'd0);
    tick();
    ic = 1'b1; redir = 1'b1; tgt = 32'h200;
    #1;
    chk("ic_c1_ctrl", 32'(ctrl), 32'(C_ICW));
    tick();
    tgt = 32'h300;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ic_pend_ctrl", 32'(ctrl), 32'(C_ICW));
      chk("ic_pend_target", pc_tgt, 32'h200);
      tick();
    end
    ic = 1'b0; redir = 1'b0;
    #1;
    chk("ic_done_ctrl", 32'(ctrl), 32'(C_REDIR));
    chk("ic_done_target", pc_tgt, 32'h200);
    tick();
    chk("ic_after_ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("ic_after_target", pc_tgt, 32'h300);
    chk("ic_stall_cnt", stall_cnt, 32'd4);
    chk("ic_redir_cnt", redir_cnt, 32'd1);

    // D-cache stall defers completion of a pending redirect
    pulse_reset();
    tick();
    ic = 1'b1; redir = 1'b1; tgt = 32'h400;
    tick();
    redir = 1'b0; tgt = 32'h0; fwd = 1'b1;
    #1;
    chk("pend_fwd_ctrl", 32'(ctrl), 32'(C_ICWB));
    tick();
    ic = 1'b0; dc = 1'b1;
    #1;
    chk("pend_dc_ctrl", 32'(ctrl), 32'(C_DC));
    tick();
    dc = 1'b0; fwd = 1'b0;
    #1;
    chk("pend_dc_done_ctrl", 32'(ctrl), 32'(C_REDIR));
    chk("pend_dc_done_target", pc_tgt, 32'h400);
    tick();
    chk("pend_dc_after_ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("pend_dc_stall_cnt", stall_cnt, 32'd3);
    chk("pend_dc_redir_cnt", redir_cnt, 32'd1);

    // Reset in the middle of PEND discards the held redirect
    ic = 1'b1; redir = 1'b1; tgt = 32'h500;
    tick();
    redir = 1'b0; tgt = 32'h0;
    #1;
    chk("pend_rst_pre_ctrl", 32'(ctrl), 32'(C_ICW));
    rst = 1'b1;
    #1;
    chk("pend_rst_ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("pend_rst_target", pc_tgt, 32'h0);
    chk("pend_rst_stall_cnt", stall_cnt, 32'h0);
    ic = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("pend_rst_rel_ctrl", 32'(ctrl), 32'(C_IDLE));
    tick();
    chk("pend_rst_next_ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("pend_rst_redir_cnt", redir_cnt, 32'h0);

    // Counter saturation on the narrow instance
    dc = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    dc = 1'b0;
    #1;
    chk("sat_stall_cnt4", 32'(stall_cnt4), 32'hF);
    chk("sat_stall_cnt32", stall_cnt, 32'd20);
    tick();
    chk("sat_hold_cnt4", 32'(stall_cnt4), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
